// File: rtl/tqvp_spi_master.sv
`default_nettype none
// ============================================================================
// tqvp_spi_master : byte-oriented mode-0 SPI master with 4-deep TX/RX FIFOs
// Rev 1.0 - initial release
// ============================================================================
module tqvp_spi_master (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  ui_in,
  output logic [7:0]  uo_out,
  input  logic [5:0]  address,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic        user_interrupt
);

  localparam logic [5:0] C_ADDR_DATA = 6'h00;
  localparam logic [5:0] C_ADDR_STAT = 6'h04;
  localparam logic [5:0] C_ADDR_CTRL = 6'h08;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t      r_state, w_state_nxt;

  logic        w_wr, w_rd, w_sel_data, w_sel_stat, w_sel_ctrl;
  logic [7:0]  r_div;
  logic        r_irq_en, r_ovf;

  logic [7:0]  r_tx_mem [4];
  logic [1:0]  r_tx_wp, r_tx_rp;
  logic [2:0]  r_tx_cnt;
  logic        w_tx_full, w_tx_empty, w_tx_push, w_tx_pop, w_tx_drop;
  logic [7:0]  w_tx_head;

  logic [7:0]  r_rx_mem [4];
  logic [1:0]  r_rx_wp, r_rx_rp;
  logic [2:0]  r_rx_cnt;
  logic        w_rx_full, w_rx_empty, w_rx_push, w_rx_pop, w_rx_drop;
  logic [7:0]  w_rx_head;

  logic [7:0]  r_shreg, r_div_cnt;
  logic [3:0]  r_bit_cnt;
  logic        r_sck, r_mosi, r_cs_n;
  logic        w_tick, w_rise, w_fall, w_done;
  logic        w_unused;

  assign w_wr       = (data_write_n != 2'b11);
  assign w_rd       = (data_read_n != 2'b11);
  assign w_sel_data = (address == C_ADDR_DATA);
  assign w_sel_stat = (address == C_ADDR_STAT);
  assign w_sel_ctrl = (address == C_ADDR_CTRL);

  assign w_tx_full  = (r_tx_cnt == 3'd4);
  assign w_tx_empty = (r_tx_cnt == 3'd0);
  assign w_tx_head  = r_tx_mem[r_tx_rp];
  assign w_rx_full  = (r_rx_cnt == 3'd4);
  assign w_rx_empty = (r_rx_cnt == 3'd0);
  assign w_rx_head  = r_rx_mem[r_rx_rp];

  // A full FIFO still accepts a push when the same cycle pops it
  assign w_tx_push = w_wr & w_sel_data & (~w_tx_full | w_tx_pop);
  assign w_tx_drop = w_wr & w_sel_data & ~w_tx_push;
  assign w_rx_pop  = w_rd & w_sel_data & ~w_rx_empty;
  assign w_rx_push = w_done & (~w_rx_full | w_rx_pop);
  assign w_rx_drop = w_done & ~w_rx_push;

  always_comb begin
    w_state_nxt = r_state;
    w_tick      = 1'b0;
    w_rise      = 1'b0;
    w_fall      = 1'b0;
    w_done      = 1'b0;
    w_tx_pop    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_tx_empty) begin
          w_tx_pop    = 1'b1;
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        w_tick = (r_div_cnt == 8'd0);
        w_rise = w_tick & ~r_sck;
        w_fall = w_tick & r_sck;
        w_done = w_fall & (r_bit_cnt == 4'd8);
        if (w_done) begin
          if (w_tx_empty) w_state_nxt = S_IDLE;
          else            w_tx_pop    = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_shreg   <= 8'h00;
      r_div_cnt <= 8'h00;
      r_bit_cnt <= 4'd0;
      r_sck     <= 1'b0;
      r_mosi    <= 1'b0;
      r_cs_n    <= 1'b1;
    end else if (w_tx_pop) begin
      r_shreg   <= w_tx_head;
      r_mosi    <= w_tx_head[7];
      r_sck     <= 1'b0;
      r_div_cnt <= r_div;
      r_bit_cnt <= 4'd0;
      r_cs_n    <= 1'b0;
    end else if (r_state == S_SHIFT) begin
      if (w_done) begin
        r_cs_n <= 1'b1;
        r_sck  <= 1'b0;
        r_mosi <= 1'b0;
      end else if (w_tick) begin
        r_div_cnt <= r_div;
        r_sck     <= ~r_sck;
        if (w_rise) begin
          r_shreg   <= {r_shreg[6:0], ui_in[2]};
          r_bit_cnt <= r_bit_cnt + 4'd1;
        end else if (w_fall) begin
          r_mosi <= r_shreg[7];
        end
      end else begin
        r_div_cnt <= r_div_cnt - 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wp] <= data_in[7:0];
    if (w_rx_push) r_rx_mem[r_rx_wp] <= r_shreg;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tx_wp  <= 2'd0;
      r_tx_rp  <= 2'd0;
      r_tx_cnt <= 3'd0;
      r_rx_wp  <= 2'd0;
      r_rx_rp  <= 2'd0;
      r_rx_cnt <= 3'd0;
    end else begin
      if (w_tx_push) r_tx_wp <= r_tx_wp + 2'd1;
      if (w_tx_pop)  r_tx_rp <= r_tx_rp + 2'd1;
      case ({w_tx_push, w_tx_pop})
        2'b10:   r_tx_cnt <= r_tx_cnt + 3'd1;
        2'b01:   r_tx_cnt <= r_tx_cnt - 3'd1;
        default: r_tx_cnt <= r_tx_cnt;
      endcase
      if (w_rx_push) r_rx_wp <= r_rx_wp + 2'd1;
      if (w_rx_pop)  r_rx_rp <= r_rx_rp + 2'd1;
      case ({w_rx_push, w_rx_pop})
        2'b10:   r_rx_cnt <= r_rx_cnt + 3'd1;
        2'b01:   r_rx_cnt <= r_rx_cnt - 3'd1;
        default: r_rx_cnt <= r_rx_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_div    <= 8'h00;
      r_irq_en <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_wr && w_sel_ctrl) begin
        r_div <= data_in[7:0];
        if (data_write_n != 2'b00) r_irq_en <= data_in[8];
      end
      // An overflow in the same cycle as a clear keeps the flag set
      if (w_tx_drop || w_rx_drop)                r_ovf <= 1'b1;
      else if (w_wr && w_sel_stat && data_in[5]) r_ovf <= 1'b0;
    end
  end

  always_comb begin
    data_out = 32'h0;
    case (address)
      C_ADDR_DATA: data_out = {24'h0, (w_rx_empty ? 8'h00 : w_rx_head)};
      C_ADDR_STAT: data_out = {26'h0, r_ovf, w_rx_full, w_rx_empty,
                               w_tx_empty, w_tx_full, (r_state != S_IDLE)};
      C_ADDR_CTRL: data_out = {23'h0, r_irq_en, r_div};
      default:     data_out = 32'h0;
    endcase
  end

  assign uo_out         = {2'b00, r_cs_n, r_mosi, r_sck, 3'b000};
  assign data_ready     = 1'b1;
  assign user_interrupt = r_irq_en & ~w_rx_empty;
  assign w_unused       = &{1'b0, ui_in[7:3], ui_in[1:0], data_in[31:9]};

endmodule
`default_nettype wire

// File: tb/tb_tqvp_spi_master.sv
`default_nettype none
// ============================================================================
// tb_tqvp_spi_master : scoreboard testbench for tqvp_spi_master
// Rev 1.0 - initial release
// ============================================================================
module tb_tqvp_spi_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  ui_in;
  logic [7:0]  uo_out;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic [31:0] data_out;
  logic        data_ready;
  logic        user_interrupt;
  logic        miso = 1'b0;

  int          n_tests = 0;
  int          n_fail  = 0;
  bit          abort   = 1'b0;
  int          exp_period = 4;

  logic [31:0] q_rd[$];
  logic [7:0]  q_mosi[$];
  logic [7:0]  q_miso[$];
  int          q_cs[$];

  assign ui_in = {5'b0, miso, 2'b00};

  always #5 clk = ~clk;

  tqvp_spi_master dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ui_in          (ui_in),
    .uo_out         (uo_out),
    .address        (address),
    .data_in        (data_in),
    .data_write_n   (data_write_n),
    .data_read_n    (data_read_n),
    .data_out       (data_out),
    .data_ready     (data_ready),
    .user_interrupt (user_interrupt)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic fail_unexpected(input string nm, input logic [31:0] act);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got 0x%0h, expected nothing queued", nm, act);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [5:0] a, input logic [31:0] d, input logic [1:0] wn);
    address = a; data_in = d; data_write_n = wn;
    @(posedge clk); #1;
    data_write_n = 2'b11;
  endtask

  task automatic bus_read(input logic [5:0] a, input logic [31:0] exp);
    q_rd.push_back(exp);
    address = a; data_read_n = 2'b00;
    @(posedge clk); #1;
    data_read_n = 2'b11;
  endtask

  task automatic wait_cs(input logic val, input int max, input string nm, output int n);
    n = 0;
    while (uo_out[5] !== val && n < max) begin
      tick(1);
      n++;
    end
    check(nm, {31'h0, uo_out[5]}, {31'h0, val});
  endtask

  // Monitor: bus read scoreboard plus SPI line decoding
  initial begin
    logic       prev_sck = 1'b0;
    int         cyc = 0, last_rise = 0, cs_len = 0, mbits = 0;
    bit         have_rise = 1'b0;
    logic [7:0] mbyte = 8'h00;
    forever begin
      @(negedge clk);
      cyc++;
      if (data_read_n != 2'b11) begin
        if (q_rd.size() == 0) fail_unexpected("bus_read", data_out);
        else                  check("bus_read", data_out, q_rd.pop_front());
      end
      if (abort) begin
        cs_len = 0; mbits = 0; have_rise = 1'b0;
      end else if (uo_out[5] == 1'b0) begin
        cs_len++;
        if (uo_out[3] && !prev_sck) begin
          mbyte = {mbyte[6:0], uo_out[4]};
          mbits++;
          if (have_rise) check("sck_period", cyc - last_rise, exp_period);
          have_rise = 1'b1;
          last_rise = cyc;
          if (mbits == 8) begin
            mbits = 0;
            if (q_mosi.size() == 0) fail_unexpected("mosi_byte", {24'h0, mbyte});
            else                    check("mosi_byte", {24'h0, mbyte}, {24'h0, q_mosi.pop_front()});
          end
        end
      end else begin
        if (cs_len != 0) begin
          if (q_cs.size() == 0) fail_unexpected("cs_low_len", cs_len);
          else                  check("cs_low_len", cs_len, q_cs.pop_front());
        end
        cs_len = 0; mbits = 0; have_rise = 1'b0;
      end
      prev_sck = uo_out[3];
    end
  end

  // Mode-0 slave: presents bit 7 at CS fall, shifts on each falling SCK
  initial begin
    logic       ps = 1'b0, pc = 1'b1;
    logic [7:0] sb = 8'h00;
    int         idx = 0;
    forever begin
      @(negedge clk);
      if (abort) begin
        idx = 0; miso = 1'b0;
      end else if (pc && !uo_out[5]) begin
        sb = (q_miso.size() != 0) ? q_miso.pop_front() : 8'h00;
        idx = 0;
        miso = sb[7];
      end else if (ps && !uo_out[3] && !uo_out[5]) begin
        idx++;
        if (idx == 8) begin
          sb = (q_miso.size() != 0) ? q_miso.pop_front() : 8'h00;
          idx = 0;
        end
        miso = sb[7 - idx];
      end
      ps = uo_out[3];
      pc = uo_out[5];
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] t3_tx [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    logic [7:0] t3_rx [5] = '{8'h81, 8'h42, 8'h24, 8'h18, 8'hE7};
    logic [7:0] t4_rx [5] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5};
    int n;

    rst_n = 1'b0; address = 6'h0; data_in = 32'h0;
    data_write_n = 2'b11; data_read_n = 2'b11;
    tick(3);
    check("rst_uo_out", {24'h0, uo_out}, 32'h20);
    check("rst_irq", {31'h0, user_interrupt}, 32'h0);
    check("data_ready", {31'h0, data_ready}, 32'h1);
    rst_n = 1'b1;
    bus_read(6'h04, 32'h0000_000C);
    bus_read(6'h08, 32'h0);

    // Single byte, DIV=1: MOSI 0xA5, slave returns 0x3C, CS low 32 cycles
    bus_write(6'h08, 32'h1, 2'b10);
    exp_period = 4;
    q_mosi.push_back(8'hA5); q_miso.push_back(8'h3C); q_cs.push_back(32);
    bus_write(6'h00, 32'hA5, 2'b00);
    wait_cs(1'b0, 10, "t2_cs_fall", n);
    check("t2_cs_latency", n, 1);   // push edge already passed; one more edge loads the FSM
    wait_cs(1'b1, 100, "t2_cs_rise", n);
    bus_read(6'h00, 32'h3C);
    bus_read(6'h04, 32'h0C);

    // Five bytes back-to-back at DIV=0; fifth byte overflows RX
    bus_write(6'h08, 32'h0, 2'b10);
    exp_period = 2;
    for (int i = 0; i < 5; i++) begin
      q_mosi.push_back(t3_tx[i]);
      q_miso.push_back(t3_rx[i]);
    end
    q_cs.push_back(80);
    for (int i = 0; i < 5; i++) bus_write(6'h00, {24'h0, t3_tx[i]}, 2'b00);
    wait_cs(1'b0, 10, "t3_cs_fall", n);
    wait_cs(1'b1, 200, "t3_cs_rise", n);
    bus_read(6'h04, 32'h34);
    for (int i = 0; i < 4; i++) bus_read(6'h00, {24'h0, t3_rx[i]});
    bus_read(6'h04, 32'h2C);
    bus_write(6'h04, 32'h20, 2'b10);
    bus_read(6'h04, 32'h0C);

    // Interrupt enabled, five bytes with no reads
    bus_write(6'h08, 32'h100, 2'b10);
    for (int i = 0; i < 5; i++) begin
      q_mosi.push_back(8'(i + 1));
      q_miso.push_back(t4_rx[i]);
    end
    q_cs.push_back(80);
    bus_write(6'h00, 32'h01, 2'b00);
    wait_cs(1'b0, 10, "t4_cs_fall", n);
    check("t4_irq_early", {31'h0, user_interrupt}, 32'h0);
    for (int i = 1; i < 5; i++) bus_write(6'h00, i + 1, 2'b00);
    n = 0;
    while (!user_interrupt && n < 100) begin
      tick(1);
      n++;
    end
    check("t4_irq_delay", n, 12);   // 16 cycles after CS fall, 4 already spent writing
    wait_cs(1'b1, 200, "t4_cs_rise", n);
    bus_read(6'h04, 32'h34);
    check("t4_irq_high", {31'h0, user_interrupt}, 32'h1);
    bus_write(6'h04, 32'h20, 2'b10);
    bus_read(6'h04, 32'h14);

    // RX full: bus pop on the same edge as the RX push
    q_mosi.push_back(8'h66); q_miso.push_back(8'h5A); q_cs.push_back(16);
    bus_write(6'h00, 32'h66, 2'b00);
    wait_cs(1'b0, 10, "t5_cs_fall", n);
    tick(15);
    bus_read(6'h00, 32'hA1);
    bus_read(6'h04, 32'h14);
    bus_read(6'h00, 32'hB2);
    bus_read(6'h00, 32'hC3);
    bus_read(6'h00, 32'hD4);
    bus_read(6'h00, 32'h5A);
    bus_read(6'h04, 32'h0C);
    check("t5_irq_low", {31'h0, user_interrupt}, 32'h0);

    // Empty read returns 0 and leaves pointers intact
    bus_read(6'h00, 32'h0);
    bus_read(6'h04, 32'h0C);
    q_mosi.push_back(8'h77); q_miso.push_back(8'h96); q_cs.push_back(16);
    bus_write(6'h00, 32'h77, 2'b00);
    wait_cs(1'b0, 10, "t5b_cs_fall", n);
    wait_cs(1'b1, 100, "t5b_cs_rise", n);
    bus_read(6'h00, 32'h96);
    bus_read(6'h3C, 32'h0);

    // Reset in the middle of a byte
    bus_write(6'h08, 32'h3, 2'b10);
    exp_period = 8;
    q_miso.push_back(8'hFF);
    bus_write(6'h00, 32'h5A, 2'b00);
    wait_cs(1'b0, 10, "t6_cs_fall", n);
    tick(10);
    abort = 1'b1;
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    check("t6_uo_out", {24'h0, uo_out}, 32'h20);
    check("t6_irq", {31'h0, user_interrupt}, 32'h0);
    bus_read(6'h04, 32'h0C);
    bus_read(6'h08, 32'h0);
    tick(2);
    abort = 1'b0;
    tick(4);

    check("q_rd_left", q_rd.size(), 0);
    check("q_mosi_left", q_mosi.size(), 0);
    check("q_cs_left", q_cs.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
